// File: rtl/qtable_policy_reader.sv
// Q-table policy read-back: sweeps all states, reads every action Q-value and
// streams one (state, greedy action, max Q) record per state on valid/ready.
module qtable_policy_reader #(
    parameter int STATES_WIDTH  = 4,
    parameter int ACTIONS_WIDTH = 2,
    parameter int NUM_STATES    = 16,
    parameter int NUM_ACTIONS   = 4,
    parameter int Q_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_start,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_rd_en,
    output logic [STATES_WIDTH+ACTIONS_WIDTH-1:0]  o_rd_addr,
    input  logic [Q_WIDTH-1:0]                     i_rd_data,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [STATES_WIDTH-1:0]                o_state,
    output logic [ACTIONS_WIDTH-1:0]               o_action,
    output logic [Q_WIDTH-1:0]                     o_q_max
);

    localparam logic [STATES_WIDTH-1:0]  S_LAST = STATES_WIDTH'(NUM_STATES - 1);
    localparam logic [ACTIONS_WIDTH-1:0] A_LAST = ACTIONS_WIDTH'(NUM_ACTIONS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_OUT, ST_DONE} state_t;

    state_t                    state, state_nxt;
    logic [STATES_WIDTH-1:0]   s_cnt;
    logic [ACTIONS_WIDTH-1:0]  a_cnt;
    logic                      rd_pend;
    logic [ACTIONS_WIDTH-1:0]  rd_act;
    logic signed [Q_WIDTH-1:0] best_q, best_q_nxt;
    logic [ACTIONS_WIDTH-1:0]  best_a, best_a_nxt;
    logic                      take;

    always_ff @(posedge clk) begin
        if (rst_n) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_READ;
            ST_READ: if (a_cnt == A_LAST) state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_OUT;
            ST_OUT:  if (i_ready) state_nxt = (s_cnt == S_LAST) ? ST_DONE : ST_READ;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == ST_READ) || (state == ST_WAIT) || (state == ST_OUT);
        o_done  = (state == ST_DONE);
        o_rd_en = (state == ST_READ);
        o_valid = (state == ST_OUT);
    end

    assign o_rd_addr = {s_cnt, a_cnt};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s_cnt <= '0;
            a_cnt <= '0;
        end else begin
            if (state == ST_IDLE && i_start) begin
                s_cnt <= '0;
                a_cnt <= '0;
            end
            if (state == ST_READ)
                a_cnt <= (a_cnt == A_LAST) ? '0 : a_cnt + 1'b1;
            if (state == ST_OUT && i_ready && s_cnt != S_LAST)
                s_cnt <= s_cnt + 1'b1;
        end
    end

    // Read data lands one cycle after the strobe; action 0 always seeds the max,
    // later actions replace it only when strictly greater so ties keep the lowest index.
    always_comb begin
        take       = rd_pend && ((rd_act == '0) || ($signed(i_rd_data) > best_q));
        best_q_nxt = take ? $signed(i_rd_data) : best_q;
        best_a_nxt = take ? rd_act : best_a;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_pend  <= 1'b0;
            rd_act   <= '0;
            best_q   <= '0;
            best_a   <= '0;
            o_state  <= '0;
            o_action <= '0;
            o_q_max  <= '0;
        end else begin
            rd_pend <= (state == ST_READ);
            rd_act  <= a_cnt;
            best_q  <= best_q_nxt;
            best_a  <= best_a_nxt;
            // WAIT folds in the last action, so the record is loaded from the next-state values.
            if (state == ST_WAIT) begin
                o_state  <= s_cnt;
                o_action <= best_a_nxt;
                o_q_max  <= best_q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_qtable_policy_reader.sv
// Directed bench for qtable_policy_reader: default 16x4 instance plus a 4x1 instance.
module tb_qtable_policy_reader;

    logic        clk, rst_n;
    logic        i_start, i_ready;
    logic        busy, done, rd_en, valid;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data, qmax;
    logic [3:0]  st;
    logic [1:0]  act;

    logic        i_start1, i_ready1;
    logic        busy1, done1, rd_en1, valid1;
    logic [2:0]  rd_addr1;
    logic [31:0] rd_data1, qmax1;
    logic [1:0]  st1;
    logic [0:0]  act1;

    logic [31:0] mem  [64];
    logic [31:0] mem1 [8];

    int n_cmp = 0;
    int n_err = 0;

    int          rec_n, rd_n, done_n, done_c, out_rd_n, stall_bad, stall_acc_c;
    int          rec_s [32];
    int          rec_a [32];
    int          rec_c [32];
    logic [31:0] rec_q [32];
    logic [5:0]  rd_addr_log [128];
    int          rd_cyc_log  [128];

    qtable_policy_reader #(
        .STATES_WIDTH(4), .ACTIONS_WIDTH(2), .NUM_STATES(16), .NUM_ACTIONS(4), .Q_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_valid(valid),
        .i_ready(i_ready), .o_state(st), .o_action(act), .o_q_max(qmax)
    );

    qtable_policy_reader #(
        .STATES_WIDTH(2), .ACTIONS_WIDTH(1), .NUM_STATES(4), .NUM_ACTIONS(1), .Q_WIDTH(32)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start1), .o_busy(busy1), .o_done(done1),
        .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1), .o_valid(valid1),
        .i_ready(i_ready1), .o_state(st1), .o_action(act1), .o_q_max(qmax1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en1) rd_data1 <= mem1[rd_addr1];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one sweep from a negedge; cycle numbers count from the i_start cycle (0).
    task automatic sweep(input int stall_s, input int stall_len, input int pulse_c, input int max_c);
        int used;
        logic [3:0]  snap_s;
        logic [1:0]  snap_a;
        logic [31:0] snap_q;
        rec_n = 0; rd_n = 0; done_n = 0; done_c = -1; out_rd_n = 0;
        stall_bad = 0; stall_acc_c = -1; used = 0;
        snap_s = '0; snap_a = '0; snap_q = '0;
        i_ready = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= max_c; cyc++) begin
            i_start = (cyc == pulse_c);
            if (rd_en) begin
                if (rd_n < 128) begin
                    rd_addr_log[rd_n] = rd_addr;
                    rd_cyc_log[rd_n]  = cyc;
                end
                rd_n++;
            end
            if (done) begin
                done_n++;
                done_c = cyc;
            end
            i_ready = 1'b1;
            if (valid) begin
                if (rd_en) out_rd_n++;
                if (int'(st) == stall_s && used < stall_len) begin
                    if (used == 0) begin
                        snap_s = st; snap_a = act; snap_q = qmax;
                    end else if (st !== snap_s || act !== snap_a || qmax !== snap_q) begin
                        stall_bad++;
                    end
                    used++;
                    i_ready = 1'b0;
                end else begin
                    if (used > 0 && int'(st) == stall_s) begin
                        if (st !== snap_s || act !== snap_a || qmax !== snap_q) stall_bad++;
                        stall_acc_c = cyc;
                    end
                    if (rec_n < 32) begin
                        rec_s[rec_n] = int'(st);
                        rec_a[rec_n] = int'(act);
                        rec_q[rec_n] = qmax;
                        rec_c[rec_n] = cyc;
                    end
                    rec_n++;
                end
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        int bad, found, n1, dn1, dc1;
        int r1_s [4];
        int r1_a [4];
        int r1_c [4];
        logic [31:0] r1_q [4];

        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        mem1[0] = 32'd10; mem1[2] = 32'hFFFF_FFFD; mem1[4] = 32'd7; mem1[6] = 32'd0;
        mem1[1] = 32'd99; mem1[3] = 32'd99; mem1[5] = 32'd99; mem1[7] = 32'd99;
        rd_data = '0; rd_data1 = '0;
        rst_n = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_start1 = 1'b0; i_ready1 = 1'b1;

        // Reset with noisy inputs, i_start held high at the end
        repeat (4) begin
            @(negedge clk);
            i_start = 1'($urandom);
            i_ready = 1'($urandom);
        end
        i_start = 1'b1;
        @(negedge clk);
        check_eq("rst_busy",   64'(busy),    64'(0));
        check_eq("rst_valid",  64'(valid),   64'(0));
        check_eq("rst_done",   64'(done),    64'(0));
        check_eq("rst_rd_en",  64'(rd_en),   64'(0));
        check_eq("rst_addr",   64'(rd_addr), 64'(0));
        check_eq("rst_state",  64'(st),      64'(0));
        check_eq("rst_action", 64'(act),     64'(0));
        check_eq("rst_qmax",   64'(qmax),    64'(0));
        rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'(0));

        // Ramp table Q(s,a) = 4s+a
        sweep(-1, 0, 0, 110);
        check_eq("ramp_nrec", 64'(rec_n), 64'(16));
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("ramp%0d_state", i), 64'(rec_s[i]), 64'(i));
            check_eq($sformatf("ramp%0d_action", i), 64'(rec_a[i]), 64'(3));
            check_eq($sformatf("ramp%0d_q", i), 64'(rec_q[i]), 64'(32'(4 * i + 3)));
            check_eq($sformatf("ramp%0d_cyc", i), 64'(rec_c[i]), 64'(6 + 6 * i));
        end
        check_eq("ramp_nrd", 64'(rd_n), 64'(64));
        bad = -1;
        for (int i = 0; i < 64; i++)
            if (rd_addr_log[i] != 6'(i) && bad < 0) bad = i;
        check_eq("ramp_rd_order", 64'(bad), 64'(-1));
        check_eq("ramp_first_rd_cyc", 64'(rd_cyc_log[0]), 64'(1));
        check_eq("ramp_ndone", 64'(done_n), 64'(1));
        check_eq("ramp_done_cyc", 64'(done_c), 64'(97));
        check_eq("ramp_out_rd", 64'(out_rd_n), 64'(0));
        check_eq("ramp_idle_busy", 64'(busy), 64'(0));
        check_eq("ramp_idle_valid", 64'(valid), 64'(0));
        check_eq("ramp_hold_state", 64'(st), 64'(15));
        check_eq("ramp_hold_q", 64'(qmax), 64'(63));

        // Signed values, ties, 3-cycle stall on state 2, stray i_start mid-sweep
        mem[0] = 32'hFFFF_FFFB; mem[1] = 32'hFFFF_FFFE; mem[2] = 32'hFFFF_FFF9; mem[3] = 32'hFFFF_FFFE;
        for (int i = 4; i < 8; i++) mem[i] = 32'h8000_0000;
        sweep(2, 3, 30, 110);
        check_eq("sgn_s0_action", 64'(rec_a[0]), 64'(1));
        check_eq("sgn_s0_q", 64'(rec_q[0]), 64'(32'hFFFF_FFFE));
        check_eq("sgn_s1_action", 64'(rec_a[1]), 64'(0));
        check_eq("sgn_s1_q", 64'(rec_q[1]), 64'(32'h8000_0000));
        check_eq("bp_s2_state", 64'(rec_s[2]), 64'(2));
        check_eq("bp_s2_q", 64'(rec_q[2]), 64'(11));
        check_eq("bp_stable", 64'(stall_bad), 64'(0));
        check_eq("bp_accept_cyc", 64'(stall_acc_c), 64'(21));
        check_eq("bp_out_rd", 64'(out_rd_n), 64'(0));
        check_eq("bp_s3_addr", 64'(rd_addr_log[12]), 64'(6'h0C));
        check_eq("bp_s3_rd_cyc", 64'(rd_cyc_log[12]), 64'(22));
        check_eq("hz_nrec", 64'(rec_n), 64'(16));
        check_eq("hz_ndone", 64'(done_n), 64'(1));
        check_eq("bp_done_cyc", 64'(done_c), 64'(100));

        // Reset during READ of state 5
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            if (rd_en && rd_addr == 6'h15) found = 1;
            else @(negedge clk);
        end
        check_eq("abort_reach", 64'(found), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_eq("abort_valid", 64'(valid), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_rd_en", 64'(rd_en), 64'(0));
        check_eq("abort_state", 64'(st), 64'(0));
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || valid) done_n++;
        end
        check_eq("abort_no_done", 64'(done_n), 64'(0));
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("restart_rd_en", 64'(rd_en), 64'(1));
        check_eq("restart_addr", 64'(rd_addr), 64'(0));
        found = 0;
        for (int c = 0; c < 120 && found == 0; c++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        check_eq("restart_done", 64'(found), 64'(1));

        // Single-action configuration
        i_start1 = 1'b1;
        @(negedge clk);
        i_start1 = 1'b0;
        n1 = 0; dn1 = 0; dc1 = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (valid1) begin
                if (n1 < 4) begin
                    r1_s[n1] = int'(st1); r1_a[n1] = int'(act1);
                    r1_q[n1] = qmax1;     r1_c[n1] = cyc;
                end
                n1++;
            end
            if (done1) begin
                dn1++;
                dc1 = cyc;
            end
            @(negedge clk);
        end
        check_eq("one_nrec", 64'(n1), 64'(4));
        check_eq("one_r0_q", 64'(r1_q[0]), 64'(10));
        check_eq("one_r1_q", 64'(r1_q[1]), 64'(32'hFFFF_FFFD));
        check_eq("one_r2_q", 64'(r1_q[2]), 64'(7));
        check_eq("one_r3_q", 64'(r1_q[3]), 64'(0));
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("one_r%0d_state", i), 64'(r1_s[i]), 64'(i));
            check_eq($sformatf("one_r%0d_action", i), 64'(r1_a[i]), 64'(0));
            check_eq($sformatf("one_r%0d_cyc", i), 64'(r1_c[i]), 64'(3 + 3 * i));
        end
        check_eq("one_ndone", 64'(dn1), 64'(1));
        check_eq("one_done_cyc", 64'(dc1), 64'(13));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qtable_policy_reader.md
Name: qtable_policy_reader

Overview:
- Read-back engine for the Q-table that the Q-learning datapath writes during training.
- After training, it sweeps every state, reads all action Q-values, and picks the greedy action (argmax).
- Emits one (state, best action, max Q) record per state on a valid/ready stream, for policy export and checking.
- Sits beside the datapath on the Q-table read port, under control of the top-level controller.

Parameters:
STATES_WIDTH, 4, state index width
ACTIONS_WIDTH, 2, action index width
NUM_STATES, 16, states swept (at most 2**STATES_WIDTH)
NUM_ACTIONS, 4, actions per state (at most 2**ACTIONS_WIDTH, at least 1)
Q_WIDTH, 32, signed two's-complement fixed-point Q-value width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-high (asserted = 1); name kept for codebase consistency
i_start  in  1  one-cycle pulse that begins a sweep
o_busy  out  1  high from the cycle after the accepted i_start until the sweep finishes
o_done  out  1  one-cycle pulse after the last record is accepted
o_rd_en  out  1  Q-table read strobe
o_rd_addr  out  STATES_WIDTH+ACTIONS_WIDTH  read address {state, action}, state in the MSBs
i_rd_data  in  Q_WIDTH  Q-table read data; valid exactly 1 cycle after o_rd_en
o_valid  out  1  output record valid
i_ready  in  1  downstream accepts the record
o_state  out  STATES_WIDTH  record state index
o_action  out  ACTIONS_WIDTH  greedy action for o_state
o_q_max  out  Q_WIDTH  signed Q-value of o_action

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: when rst_n=1 at a clk edge, go to IDLE. All outputs, the state counter, the action counter and the best-value registers clear to 0. Reset takes priority over all other inputs, including mid-sweep; no o_done is produced for an aborted sweep.
- FSM states: IDLE, READ, WAIT, OUT, DONE.
- IDLE:
  - o_busy=0.
  - On i_start=1, clear the state counter s=0 and go to READ.
- READ:
  - Lasts NUM_ACTIONS cycles.
  - Each cycle: o_rd_en=1, o_rd_addr={s,a}, with a counting 0..NUM_ACTIONS-1.
  - After a=NUM_ACTIONS-1, go to WAIT.
  - o_rd_en=0 in every other state.
- Compare, on the cycle after each read strobe:
  - Data for a=0 loads best_q and best_a unconditionally.
  - For a>0, update only if i_rd_data > best_q (signed, strictly greater).
  - Ties therefore keep the lowest action index.
  - Comparison is over the full Q_WIDTH; no truncation or saturation.
- WAIT: one cycle. Captures the data for the last action, then go to OUT.
- OUT:
  - o_valid=1; o_state=s, o_action=best_a, o_q_max=best_q.
  - All three are held stable while i_ready=0; no reads are issued.
  - On o_valid and i_ready, if s=NUM_STATES-1, go to DONE.
  - Otherwise s<=s+1 and go to READ.
  - o_valid drops the cycle after the handshake.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then go to IDLE.
- o_busy is 1 in READ, WAIT and OUT.
- i_start is ignored in every state except IDLE, including the DONE cycle.
- Latency with i_ready held high:
  - i_start accepted at cycle 0; READ in cycles 1..NUM_ACTIONS; WAIT in cycle NUM_ACTIONS+1; first o_valid in cycle NUM_ACTIONS+2.
  - Period is NUM_ACTIONS+2 cycles per state.
  - o_done asserts in cycle NUM_STATES*(NUM_ACTIONS+2)+1.
- NUM_ACTIONS=1: READ lasts one cycle and the record carries action 0.
- Counter s never wraps. The sweep ends at NUM_STATES-1.
- Output registers keep their last values in IDLE and DONE; o_valid=0 there.

Test Plan:
1. Reset: assert rst_n=1 with random inputs -> all outputs 0, o_busy=0; a held i_start while rst_n=1 has no effect.
2. Ramp table Q(s,a)=4s+a, i_ready=1:
   - 16 records, o_action=3 and o_q_max=4s+3 for each.
   - o_valid at cycles 6,12,...,96; o_done single pulse at cycle 97.
   - Read addresses 0..63 in order.
3. Signed values and ties: state 0 holds Q = -5,-2,-7,-2 -> o_action=1, o_q_max=-2. State 1 all = 0x80000000 -> o_action=0, o_q_max=0x80000000.
4. Backpressure: i_ready=0 for 3 cycles during state 2's OUT -> o_state, o_action and o_q_max stable; o_rd_en=0; state 3 reads begin the cycle after i_ready=1.
5. Control hazards: i_start pulsed mid-sweep is ignored and the record count stays 16. rst_n=1 during READ of state 5 -> IDLE next cycle, o_valid=0, no o_done; a fresh i_start restarts at address {0,0}.
6. Single-action config (NUM_ACTIONS=1, NUM_STATES=4): Q=10,-3,7,0 -> records (0,0,10),(1,0,-3),(2,0,7),(3,0,0); period 3 cycles; o_done at cycle 13.
